// File: rtl/stage_memory.sv
// Memory stage: passes ALU results to writeback and runs a req/ack
// bus transaction for loads and stores, stalling execute meanwhile.
module stage_memory #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  output logic        stall,
  input  logic [3:0]  in_addr,
  input  logic [31:0] in_val,
  input  logic        is_mem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  input  logic        mem_write,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_fault,
  output logic        fwd_valid,
  output logic [3:0]  fwd_addr,
  output logic [31:0] fwd_val,
  output logic [3:0]  wb_addr,
  output logic [31:0] wb_val
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              bus_fault_q, bus_fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dest_q, dest_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        wb_addr_q, wb_addr_d;
  logic [31:0]       wb_val_q, wb_val_d;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_fault_d = 1'b0;
    cnt_d       = cnt_q;
    dest_d      = dest_q;
    data_d      = data_q;
    wb_addr_d   = wb_addr_q;
    wb_val_d    = wb_val_q;
    stall       = 1'b0;
    fwd_valid   = 1'b0;
    fwd_addr    = in_addr;
    fwd_val     = in_val;

    unique case (state_q)
      IDLE: begin
        stall = stall_in | is_mem;
        if (!is_mem) begin
          fwd_valid = 1'b1;
          if (!stall_in) begin
            wb_addr_d = in_addr;
            wb_val_d  = in_val;
          end
        end else if (!stall_in) begin
          dest_d      = mem_write ? 4'd0 : in_addr;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_val;
          cnt_d       = '0;
          wb_addr_d   = 4'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (!stall_in) wb_addr_d = 4'd0;
        // An ack on the last allowed cycle beats the timeout.
        if (bus_ack) begin
          data_d    = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          data_d      = '0;
          bus_req_d   = 1'b0;
          bus_fault_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Inputs here belong to the finished op; never reissue.
        stall     = stall_in;
        fwd_valid = ~bus_we_q;
        fwd_addr  = dest_q;
        fwd_val   = data_q;
        if (!stall_in) begin
          wb_addr_d = dest_q;
          wb_val_d  = data_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_fault_q <= 1'b0;
      cnt_q       <= '0;
      dest_q      <= '0;
      data_q      <= '0;
      wb_addr_q   <= '0;
      wb_val_q    <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_fault_q <= bus_fault_d;
      cnt_q       <= cnt_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      wb_addr_q   <= wb_addr_d;
      wb_val_q    <= wb_val_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_fault = bus_fault_q;
  assign wb_addr   = wb_addr_q;
  assign wb_val    = wb_val_q;

endmodule

// File: tb/tb_stage_memory.sv
// Randomized self-checking bench for stage_memory against a
// transaction-level model of writeback and bus behaviour.
module tb_stage_memory;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic        stall;
  logic [3:0]  in_addr;
  logic [31:0] in_val;
  logic        is_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_val;
  logic        mem_write;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_fault;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_val;
  logic [3:0]  wb_addr;
  logic [31:0] wb_val;

  int checks = 0;
  int failures = 0;

  logic [3:0]  m_wb_addr;
  logic [31:0] m_wb_val;

  always #5 clk = ~clk;

  stage_memory #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .stall(stall),
    .in_addr(in_addr), .in_val(in_val), .is_mem(is_mem),
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_write(mem_write),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_fault(bus_fault), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_val(fwd_val), .wb_addr(wb_addr), .wb_val(wb_val)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    stall_in = 0; in_addr = 0; in_val = 0; is_mem = 0;
    mem_addr = 0; mem_val = 0; mem_write = 0;
    bus_ack = 0; bus_rdata = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_fault} !== 3'b000 || bus_addr !== 0 ||
        bus_wdata !== 0) begin
      failures++;
      $display("FAIL reset_bus req=%0b we=%0b flt=%0b addr=%h wd=%h exp all 0",
               bus_req, bus_we, bus_fault, bus_addr, bus_wdata);
    end
    checks++;
    if (wb_addr !== 4'd0 || wb_val !== 32'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_wb wb_addr=%0d wb_val=%h stall=%0b exp 0/0/0",
               wb_addr, wb_val, stall);
    end
    rst_n = 1'b1;
    m_wb_addr = 0;
    m_wb_val = 0;
  endtask

  task automatic nonmem(input logic [3:0] a, input logic [31:0] v,
                        input bit si, input bit noise_ack);
    in_addr = a; in_val = v; is_mem = 0; stall_in = si;
    mem_addr = $urandom; mem_write = $urandom_range(0, 1);
    bus_ack = noise_ack; bus_rdata = $urandom;
    #1;
    checks++;
    if (fwd_valid !== 1'b1 || fwd_addr !== a || fwd_val !== v ||
        stall !== si) begin
      failures++;
      $display("FAIL nonmem_fwd v=%0b a=%0d val=%h st=%0b exp 1 %0d %h %0b",
               fwd_valid, fwd_addr, fwd_val, stall, a, v, si);
    end
    @(negedge clk);
    bus_ack = 0;
    if (!si) begin
      m_wb_addr = a;
      m_wb_val = v;
    end
    checks++;
    if (wb_addr !== m_wb_addr || wb_val !== m_wb_val || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL nonmem_wb addr=%0d val=%h req=%0b exp %0d %h 0",
               wb_addr, wb_val, bus_req, m_wb_addr, m_wb_val);
    end
  endtask

  // wt = BUSY cycle index of the ack; wt >= TO means no ack at all.
  task automatic mem_op(input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] d,
                        input int wt, input logic [31:0] rd,
                        input int dst);
    bit ef;
    logic [31:0] ev;
    logic [3:0] ed;
    int n;
    ef = (wt >= TO);
    ev = ef ? 32'd0 : rd;
    ed = wr ? 4'd0 : d;
    is_mem = 1; mem_write = wr; mem_addr = a; mem_val = wd;
    in_addr = d; in_val = $urandom; stall_in = 0;
    #1;
    checks++;
    if (stall !== 1'b1 || fwd_valid !== 1'b0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL mem_issue stall=%0b fwd=%0b req=%0b exp 1 0 0",
               stall, fwd_valid, bus_req);
    end
    @(negedge clk);
    n = 0;
    while (n < TO) begin
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== a || bus_we !== wr ||
          bus_wdata !== wd || bus_fault !== 1'b0) begin
        failures++;
        $display("FAIL mem_busy cyc=%0d req=%0b addr=%h we=%0b wd=%h flt=%0b exp 1 %h %0b %h 0",
                 n, bus_req, bus_addr, bus_we, bus_wdata, bus_fault, a, wr, wd);
      end
      checks++;
      if (stall !== 1'b1 || wb_addr !== 4'd0 || fwd_valid !== 1'b0) begin
        failures++;
        $display("FAIL mem_busy_ctl cyc=%0d stall=%0b wb_addr=%0d fwd=%0b exp 1 0 0",
                 n, stall, wb_addr, fwd_valid);
      end
      if (n == wt) begin
        bus_ack = 1; bus_rdata = rd;
        @(negedge clk);
        bus_ack = 0; bus_rdata = $urandom;
        break;
      end
      n++;
      @(negedge clk);
    end
    m_wb_addr = 4'd0;
    checks++;
    if (bus_req !== 1'b0 || bus_fault !== ef) begin
      failures++;
      $display("FAIL mem_done req=%0b fault=%0b exp 0 %0b", bus_req, bus_fault, ef);
    end
    for (int i = 0; i < dst; i++) begin
      stall_in = 1;
      #1;
      checks++;
      if (stall !== 1'b1 || fwd_valid !== !wr ||
          (!wr && (fwd_addr !== d || fwd_val !== ev))) begin
        failures++;
        $display("FAIL done_hold st=%0b fv=%0b fa=%0d fval=%h exp 1 %0b %0d %h",
                 stall, fwd_valid, fwd_addr, fwd_val, !wr, d, ev);
      end
      @(negedge clk);
      checks++;
      if (wb_addr !== m_wb_addr || bus_req !== 1'b0 || bus_fault !== 1'b0) begin
        failures++;
        $display("FAIL done_stall wb_addr=%0d req=%0b flt=%0b exp %0d 0 0",
                 wb_addr, bus_req, bus_fault, m_wb_addr);
      end
    end
    stall_in = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_valid !== !wr ||
        (!wr && (fwd_addr !== d || fwd_val !== ev))) begin
      failures++;
      $display("FAIL done_fwd st=%0b fv=%0b fa=%0d fval=%h exp 0 %0b %0d %h",
               stall, fwd_valid, fwd_addr, fwd_val, !wr, d, ev);
    end
    @(negedge clk);
    m_wb_addr = ed;
    m_wb_val = ev;
    checks++;
    if (wb_addr !== ed || (!wr && wb_val !== ev) || bus_req !== 1'b0 ||
        bus_fault !== 1'b0) begin
      failures++;
      $display("FAIL mem_wb addr=%0d val=%h req=%0b flt=%0b exp %0d %h 0 0",
               wb_addr, wb_val, bus_req, bus_fault, ed, ev);
    end
    is_mem = 0;
    in_addr = 0;
  endtask

  task automatic test_nonmem();
    nonmem(4'd3, 32'h1234, 0, 0);
    nonmem(4'd7, 32'hDEAD_BEEF, 1, 0);
    nonmem(4'd9, 32'h0000_0042, 0, 1);
  endtask

  task automatic test_load_zero_wait();
    mem_op(0, 32'h100, 32'h0, 4'd5, 0, 32'hCAFE_F00D, 0);
  endtask

  task automatic test_store_wait();
    mem_op(1, 32'h200, 32'hA5A5_A5A5, 4'd6, 3, 32'h1111_2222, 0);
  endtask

  task automatic test_timeout();
    mem_op(0, 32'h300, 32'h0, 4'd8, TO, 32'h7777_7777, 0);
    mem_op(0, 32'h304, 32'h0, 4'd9, TO - 1, 32'h8888_9999, 0);
  endtask

  task automatic test_downstream_stall();
    mem_op(0, 32'h400, 32'h0, 4'd10, 1, 32'h0BAD_F00D, 2);
  endtask

  task automatic test_blocked_issue();
    is_mem = 1; mem_write = 0; mem_addr = 32'h500; in_addr = 4'd2;
    stall_in = 1;
    repeat (2) begin
      #1;
      checks++;
      if (stall !== 1'b1 || fwd_valid !== 1'b0) begin
        failures++;
        $display("FAIL blocked_ctl stall=%0b fwd=%0b exp 1 0", stall, fwd_valid);
      end
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0 || wb_addr !== m_wb_addr || wb_val !== m_wb_val) begin
        failures++;
        $display("FAIL blocked_hold req=%0b wb=%0d/%h exp 0 %0d/%h",
                 bus_req, wb_addr, wb_val, m_wb_addr, m_wb_val);
      end
    end
    is_mem = 0; stall_in = 0;
  endtask

  task automatic test_async_reset();
    is_mem = 1; mem_write = 0; mem_addr = 32'h600; in_addr = 4'd4;
    stall_in = 0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre req=%0b exp 1", bus_req);
    end
    #2;
    rst_n = 0;
    is_mem = 0; in_addr = 0; in_val = 0;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_fault, stall} !== 4'b0000 || bus_addr !== 0 ||
        bus_wdata !== 0 || wb_addr !== 0 || wb_val !== 0) begin
      failures++;
      $display("FAIL arst_now req=%0b we=%0b flt=%0b st=%0b addr=%h wb=%0d/%h exp all 0",
               bus_req, bus_we, bus_fault, stall, bus_addr, wb_addr, wb_val);
    end
    @(negedge clk);
    rst_n = 1;
    m_wb_addr = 0;
    m_wb_val = 0;
    bus_ack = 1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_ack = 0;
    repeat (2) begin
      checks++;
      if (wb_addr !== 4'd0 || wb_val !== 32'd0 || bus_req !== 1'b0 ||
          stall !== 1'b0) begin
        failures++;
        $display("FAIL arst_late_ack wb=%0d/%h req=%0b st=%0b exp 0/0 0 0",
                 wb_addr, wb_val, bus_req, stall);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        nonmem(4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        mem_op(1'($urandom_range(0, 1)), $urandom, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, TO + 1),
               $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_downstream_stall();
    test_blocked_issue();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes execute's registered result (dest, value) and memory request (is_mem, address, store data, write flag).
- Non-memory results pass to writeback with one cycle of latency.
- Loads and stores run a req/ack transaction on a word-wide data bus. The stage stalls upstream until the transaction completes.
- Provides a forwarding port, and a registered writeback port to the register file.

Parameters:
- TIMEOUT, 255: cycles bus_req may stay high without bus_ack before the access is aborted. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  Reset. Asynchronous, active-low.
- stall_in  in  1  downstream stall; holds the wb_* registers.
- stall  out  1  upstream stall, driven to the execute stage.
- in_addr  in  4  destination register from execute. 0 means no write (bubble).
- in_val  in  32  ALU result from execute.
- is_mem  in  1  current input is a load or store.
- mem_addr  in  32  byte address; bits [1:0] are passed through unchanged.
- mem_val  in  32  store data.
- mem_write  in  1  1 = store, 0 = load.
- bus_req  out  1  request valid.
- bus_we  out  1  write enable.
- bus_addr  out  32  request address.
- bus_wdata  out  32  write data.
- bus_ack  in  1  single-cycle completion strobe.
- bus_rdata  in  32  read data; valid only when bus_ack=1.
- bus_fault  out  1  one-cycle pulse on timeout.
- fwd_valid  out  1  forwarding value valid.
- fwd_addr  out  4  forwarding destination.
- fwd_val  out  32  forwarding value.
- wb_addr  out  4  registered writeback destination.
- wb_val  out  32  registered writeback value.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_fault=0, wb_addr=0, wb_val=0, counter=0.
- Reset is asynchronous: bus_req drops immediately and any outstanding access is abandoned. A late bus_ack after reset is ignored.
- stall (combinational):
  - IDLE: stall_in | is_mem.
  - BUSY: 1.
  - DONE: stall_in.
- IDLE, is_mem=0:
  - If stall_in=0: wb_addr<=in_addr, wb_val<=in_val.
  - fwd_valid=1, fwd_addr=in_addr, fwd_val=in_val.
- IDLE, is_mem=1, stall_in=0:
  - Latch mem_addr, mem_val, mem_write, and dest. Dest = in_addr for loads, 0 for stores.
  - Go to BUSY with bus_req<=1 and bus_addr, bus_wdata, bus_we registered.
  - wb_addr<=0 (bubble).
  - fwd_valid=0.
- IDLE, is_mem=1, stall_in=1: no request is issued; wb registers hold.
- BUSY:
  - bus_req, bus_addr, bus_we, bus_wdata stay stable until acknowledged.
  - Counter increments each cycle without an ack.
  - On bus_ack: capture bus_rdata, bus_req<=0, go to DONE.
  - If counter reaches TIMEOUT-1 with no ack: bus_req<=0, captured data<=0, bus_fault<=1 for one cycle, go to DONE.
  - bus_ack in the same cycle as the timeout: the ack wins and no fault is raised.
  - wb_addr<=0 each cycle unless stall_in=1.
  - fwd_valid=0.
- DONE:
  - fwd_valid=1 for loads (fwd_addr=dest, fwd_val=captured data); 0 for stores.
  - If stall_in=0: wb_addr<=dest, wb_val<=captured data, go to IDLE, stall=0 so execute advances.
  - If stall_in=1: remain in DONE.
  - Inputs seen in DONE belong to the already-completed op and are ignored. This prevents a reissue while execute holds is_mem high during the stall.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op with ack in the first BUSY cycle: stall high for 2 cycles, wb written at the end of the third cycle.
  - Each extra wait cycle adds 1.
- bus_ack while bus_req=0 is ignored. A store never writes a register: wb_addr=0.
- Counter clears on entry to BUSY.

Test Plan:
- Non-memory: in_addr=3, in_val=0x1234, is_mem=0 -> next cycle wb_addr=3, wb_val=0x1234; fwd is combinational; stall=0.
- Zero-wait load: is_mem=1, mem_write=0, mem_addr=0x100, in_addr=5; bus_ack with rdata=0xCAFEF00D in the first BUSY cycle -> stall high 2 cycles; exactly one bus_req cycle with addr 0x100; wb_addr=5, wb_val=0xCAFEF00D; inputs held by execute do not reissue.
- Store with 3 wait cycles: mem_addr=0x200, mem_val=0xA5A5A5A5 -> bus_req stable 4 cycles with we=1; wb_addr=0 throughout; stall released in DONE.
- Timeout with TIMEOUT=4 and no ack -> bus_req high exactly 4 cycles; single bus_fault pulse; load dest written with 0; ack arriving on the 4th cycle instead gives no fault.
- Downstream stall: stall_in=1 during DONE for 2 cycles -> wb registers hold, state stays DONE, stall=1; release -> writeback occurs once.
- Async reset: rst_n low mid-BUSY -> bus_req=0 immediately, all outputs at reset values; a subsequent ack produces no writeback.
